// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL constants: default widths, A/D opcodes and the master FSM state type.
package tl_ul_pkg;

   localparam int TL_ADDR_WIDTH_DEF   = 64;
   localparam int TL_DATA_WIDTH_DEF   = 64;
   localparam int TL_SOURCE_WIDTH_DEF = 3;
   localparam int TL_SINK_WIDTH_DEF   = 3;
   localparam int TL_OPCODE_WIDTH_DEF = 3;
   localparam int TL_PARAM_WIDTH_DEF  = 3;
   localparam int TL_SIZE_WIDTH_DEF   = 8;
   localparam int TIMEOUT_CYCLES_DEF  = 256;

   localparam logic [2:0] PUT_FULL_DATA    = 3'd0;
   localparam logic [2:0] PUT_PARTIAL_DATA = 3'd1;
   localparam logic [2:0] GET              = 3'd4;

   localparam logic [2:0] ACCESS_ACK      = 3'd0;
   localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      A_SEND = 2'd1,
      D_WAIT = 2'd2,
      RSP    = 2'd3
   } master_state_e;

endpackage

// File: rtl/tl_ul_size_check.sv
// Combinational legality check for a local command: natural alignment with size
// no larger than one beat, and whether the mask covers every active byte lane.
module tl_ul_size_check
   import tl_ul_pkg::*;
#(
   parameter  int STRB_W = 8,
   parameter  int SIZE_W = 8,
   localparam int OFF_W  = $clog2(STRB_W)
) (
   input  logic [OFF_W-1:0]  addr_offset_i,
   input  logic [SIZE_W-1:0] size_i,
   input  logic [STRB_W-1:0] mask_i,
   output logic              legal_o,
   output logic              full_mask_o
);

   logic [STRB_W-1:0] active_mask;

   // Sizes above one beat never match the loop, so they stay illegal.
   always_comb begin
      legal_o     = 1'b0;
      active_mask = '0;
      for (int s = 0; s <= OFF_W; s++) begin
         if (size_i == SIZE_W'(s)) begin
            legal_o = ((addr_offset_i & OFF_W'((1 << s) - 1)) == '0);
            for (int b = 0; b < STRB_W; b++) begin
               active_mask[b] = (b >= int'(addr_offset_i)) &&
                                (b < int'(addr_offset_i) + (1 << s));
            end
         end
      end
      full_mask_o = ((mask_i & active_mask) == active_mask);
   end

endmodule

// File: rtl/tilelink_ul_master.sv
// Single-outstanding TileLink-UL master: local command -> A channel, D channel -> local response.
// Define TL_MASTER_TIMEOUT_EN to give up on a missing D beat after TIMEOUT_CYCLES cycles.
module tilelink_ul_master
   import tl_ul_pkg::*;
#(
   parameter  int TL_ADDR_WIDTH   = TL_ADDR_WIDTH_DEF,
   parameter  int TL_DATA_WIDTH   = TL_DATA_WIDTH_DEF,
   parameter  int TL_SOURCE_WIDTH = TL_SOURCE_WIDTH_DEF,
   parameter  int TL_SINK_WIDTH   = TL_SINK_WIDTH_DEF,
   parameter  int TL_OPCODE_WIDTH = TL_OPCODE_WIDTH_DEF,
   parameter  int TL_PARAM_WIDTH  = TL_PARAM_WIDTH_DEF,
   parameter  int TL_SIZE_WIDTH   = TL_SIZE_WIDTH_DEF,
`ifdef TL_MASTER_TIMEOUT_EN
   parameter  int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
`endif
   localparam int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8
) (
   input  logic                       clk,
   input  logic                       rst,

   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [TL_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [TL_SIZE_WIDTH-1:0]   cmd_size,
   input  logic [TL_STRB_WIDTH-1:0]   cmd_mask,
   input  logic [TL_DATA_WIDTH-1:0]   cmd_wdata,

   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [TL_DATA_WIDTH-1:0]   rsp_rdata,
   output logic                       rsp_error,

   output logic                       a_valid,
   input  logic                       a_ready,
   output logic [TL_OPCODE_WIDTH-1:0] a_opcode,
   output logic [TL_PARAM_WIDTH-1:0]  a_param,
   output logic [TL_ADDR_WIDTH-1:0]   a_address,
   output logic [TL_SIZE_WIDTH-1:0]   a_size,
   output logic [TL_STRB_WIDTH-1:0]   a_mask,
   output logic [TL_DATA_WIDTH-1:0]   a_data,
   output logic [TL_SOURCE_WIDTH-1:0] a_source,

   input  logic                       d_valid,
   output logic                       d_ready,
   input  logic [TL_OPCODE_WIDTH-1:0] d_opcode,
   input  logic [TL_PARAM_WIDTH-1:0]  d_param,
   input  logic [TL_SIZE_WIDTH-1:0]   d_size,
   input  logic [TL_SINK_WIDTH-1:0]   d_sink,
   input  logic [TL_SOURCE_WIDTH-1:0] d_source,
   input  logic [TL_DATA_WIDTH-1:0]   d_data,
   input  logic                       d_error
);

   localparam int OFF_W = $clog2(TL_STRB_WIDTH);

   master_state_e              state_q;
   logic [TL_SOURCE_WIDTH-1:0] src_q;
   logic                       is_write_q;
   logic [TL_OPCODE_WIDTH-1:0] a_opcode_q;
   logic [TL_ADDR_WIDTH-1:0]   a_address_q;
   logic [TL_SIZE_WIDTH-1:0]   a_size_q;
   logic [TL_STRB_WIDTH-1:0]   a_mask_q;
   logic [TL_DATA_WIDTH-1:0]   a_data_q;
   logic [TL_DATA_WIDTH-1:0]   rsp_rdata_q;
   logic                       rsp_error_q;

   logic                       cmd_legal;
   logic                       cmd_full_mask;
   logic [TL_OPCODE_WIDTH-1:0] a_opcode_d;
   logic [TL_OPCODE_WIDTH-1:0] d_opcode_exp;
   logic                       rsp_error_d;
   logic                       unused_d;

`ifdef TL_MASTER_TIMEOUT_EN
   localparam int                TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0]              timeout_q;
`endif

   tl_ul_size_check #(
      .STRB_W (TL_STRB_WIDTH),
      .SIZE_W (TL_SIZE_WIDTH)
   ) u_size_check (
      .addr_offset_i (cmd_addr[OFF_W-1:0]),
      .size_i        (cmd_size),
      .mask_i        (cmd_mask),
      .legal_o       (cmd_legal),
      .full_mask_o   (cmd_full_mask)
   );

   assign a_opcode_d   = !cmd_write    ? TL_OPCODE_WIDTH'(GET) :
                         cmd_full_mask ? TL_OPCODE_WIDTH'(PUT_FULL_DATA) :
                                         TL_OPCODE_WIDTH'(PUT_PARTIAL_DATA);
   assign d_opcode_exp = is_write_q ? TL_OPCODE_WIDTH'(ACCESS_ACK) : TL_OPCODE_WIDTH'(ACCESS_ACK_DATA);
   assign rsp_error_d  = d_error | (d_source != src_q) | (d_opcode != d_opcode_exp);
   assign unused_d     = ^{d_param, d_size, d_sink};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         src_q       <= '0;
         is_write_q  <= 1'b0;
         a_opcode_q  <= '0;
         a_address_q <= '0;
         a_size_q    <= '0;
         a_mask_q    <= '0;
         a_data_q    <= '0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
`ifdef TL_MASTER_TIMEOUT_EN
         timeout_q   <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  is_write_q  <= cmd_write;
                  a_opcode_q  <= a_opcode_d;
                  a_address_q <= cmd_addr;
                  a_size_q    <= cmd_size;
                  a_mask_q    <= cmd_mask;
                  a_data_q    <= cmd_write ? cmd_wdata : '0;
                  if (cmd_legal) begin
                     state_q <= A_SEND;
                  end else begin
                     rsp_error_q <= 1'b1;
                     rsp_rdata_q <= '0;
                     state_q     <= RSP;
                  end
               end
            end
            A_SEND: begin
               if (a_ready) begin
                  state_q <= D_WAIT;
`ifdef TL_MASTER_TIMEOUT_EN
                  timeout_q <= '0;
`endif
               end
            end
            D_WAIT: begin
               if (d_valid) begin
                  rsp_rdata_q <= is_write_q ? '0 : d_data;
                  rsp_error_q <= rsp_error_d;
                  state_q     <= RSP;
               end
`ifdef TL_MASTER_TIMEOUT_EN
               else if (timeout_q == TO_LAST) begin
                  rsp_error_q <= 1'b1;
                  rsp_rdata_q <= '0;
                  state_q     <= RSP;
               end else begin
                  timeout_q <= timeout_q + TO_W'(1);
               end
`endif
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_rdata_q <= '0;
                  rsp_error_q <= 1'b0;
                  src_q       <= src_q + TL_SOURCE_WIDTH'(1);
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // cmd_ready is gated by reset so every output reads 0 while reset is held.
   assign cmd_ready = rst && (state_q == IDLE);
   assign a_valid   = (state_q == A_SEND);
   assign d_ready   = (state_q == D_WAIT);
   assign rsp_valid = (state_q == RSP);

   assign a_opcode  = a_opcode_q;
   assign a_param   = '0;
   assign a_address = a_address_q;
   assign a_size    = a_size_q;
   assign a_mask    = a_mask_q;
   assign a_data    = a_data_q;
   assign a_source  = src_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_tilelink_ul_master.sv
// Self-checking bench for tilelink_ul_master: acts as the TL slave (byte memory model),
// runs a directed vector table, hand-written corner sequences and randomized commands.
module tb_tilelink_ul_master;
   import tl_ul_pkg::*;

   typedef struct {
      bit          write;
      logic [63:0] addr;
      logic [7:0]  size;
      logic [7:0]  mask;
      logic [63:0] wdata;
      int          aDelay;
      int          dDelay;
      int          rspDelay;
      bit          dErr;
      bit          srcBad;
      bit          opBad;
      bit          earlyD;
      bit          noiseD;
      bit          expIssue;
      logic [2:0]  expOpcode;
      bit          expErr;
      logic [63:0] expRdata;
   } vec_t;

   localparam logic [4:0] F_DERR   = 5'b00001;
   localparam logic [4:0] F_SRCBAD = 5'b00010;
   localparam logic [4:0] F_OPBAD  = 5'b00100;
   localparam logic [4:0] F_EARLY  = 5'b01000;
   localparam logic [4:0] F_NOISE  = 5'b10000;

   logic        clk;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [63:0] cmd_addr;
   logic [7:0]  cmd_size;
   logic [7:0]  cmd_mask;
   logic [63:0] cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_error;
   logic [63:0] rsp_rdata;
   logic        a_valid, a_ready;
   logic [2:0]  a_opcode, a_param, a_source;
   logic [63:0] a_address, a_data;
   logic [7:0]  a_size, a_mask;
   logic        d_valid, d_ready, d_error;
   logic [2:0]  d_opcode, d_param, d_sink, d_source;
   logic [7:0]  d_size;
   logic [63:0] d_data;

   int          checks = 0;
   int          errors = 0;
   logic [2:0]  srcModel = 3'd0;
   logic [63:0] mem [longint];

`ifdef TL_MASTER_TIMEOUT_EN
   tilelink_ul_master #(.TIMEOUT_CYCLES(16)) dut (
`else
   tilelink_ul_master dut (
`endif
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_size  (cmd_size),
      .cmd_mask  (cmd_mask),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_error (rsp_error),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_opcode  (a_opcode),
      .a_param   (a_param),
      .a_address (a_address),
      .a_size    (a_size),
      .a_mask    (a_mask),
      .a_data    (a_data),
      .a_source  (a_source),
      .d_valid   (d_valid),
      .d_ready   (d_ready),
      .d_opcode  (d_opcode),
      .d_param   (d_param),
      .d_size    (d_size),
      .d_sink    (d_sink),
      .d_source  (d_source),
      .d_data    (d_data),
      .d_error   (d_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Last-resort guard; the main sequence is bounded and finishes long before this.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic logic [63:0] memRead(input logic [63:0] addr);
      longint key;
      key = longint'(addr >> 3);
      return mem.exists(key) ? mem[key] : 64'd0;
   endfunction

   function automatic void memWrite(input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] wdata);
      logic [63:0] word;
      word = memRead(addr);
      for (int b = 0; b < 8; b++)
         if (mask[b]) word[b*8 +: 8] = wdata[b*8 +: 8];
      mem[longint'(addr >> 3)] = word;
   endfunction

   // Reference rules: natural alignment, one beat max; full mask means every touched byte enabled.
   function automatic bit modelLegal(input logic [63:0] addr, input logic [7:0] size);
      if (size > 8'd3) return 1'b0;
      return (addr % (64'd1 << size)) == 64'd0;
   endfunction

   function automatic logic [2:0] modelOpcode(input bit write, input logic [63:0] addr,
                                              input logic [7:0] size, input logic [7:0] mask);
      int first;
      int n;
      if (!write) return 3'd4;
      first = int'(addr % 64'd8);
      n     = 1 << int'(size);
      for (int b = first; b < first + n && b < 8; b++)
         if (!mask[b]) return 3'd1;
      return 3'd0;
   endfunction

   function automatic vec_t mkVec(input bit write, input logic [63:0] addr, input logic [7:0] size,
                                  input logic [7:0] mask, input logic [63:0] wdata,
                                  input int aDelay, input int dDelay, input int rspDelay,
                                  input logic [4:0] flags, input bit expIssue,
                                  input logic [2:0] expOpcode, input bit expErr,
                                  input logic [63:0] expRdata);
      vec_t v;
      v.write = write; v.addr = addr; v.size = size; v.mask = mask; v.wdata = wdata;
      v.aDelay = aDelay; v.dDelay = dDelay; v.rspDelay = rspDelay;
      v.dErr = flags[0]; v.srcBad = flags[1]; v.opBad = flags[2];
      v.earlyD = flags[3]; v.noiseD = flags[4];
      v.expIssue = expIssue; v.expOpcode = expOpcode; v.expErr = expErr; v.expRdata = expRdata;
      return v;
   endfunction

   function automatic vec_t modelVec(input bit write, input logic [63:0] addr, input logic [7:0] size,
                                     input logic [7:0] mask, input logic [63:0] wdata);
      bit legal;
      legal = modelLegal(addr, size);
      return mkVec(write, addr, size, mask, wdata, 0, 0, 0, 5'd0, legal,
                   modelOpcode(write, addr, size, mask), !legal,
                   (legal && !write) ? memRead(addr) : 64'd0);
   endfunction

   task automatic driveD(input vec_t v, input logic [2:0] src, input logic [63:0] data);
      d_valid  = 1'b1;
      d_opcode = (v.write != v.opBad) ? 3'd0 : 3'd1;
      d_param  = 3'd0;
      d_size   = v.size;
      d_sink   = 3'($urandom);
      d_source = v.srcBad ? src + 3'd1 : src;
      d_data   = data;
      d_error  = v.dErr;
   endtask

   // Runs one command end to end, starting and ending just after a falling edge.
   task automatic applyStimulus(input vec_t v);
      logic [2:0]  src;
      logic [63:0] rspData;
      src     = srcModel;
      rspData = v.write ? {$urandom, $urandom} : memRead(v.addr);
      cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
      cmd_size  = v.size; cmd_mask = v.mask; cmd_wdata = v.wdata;
      checkOutput("cmd_ready", cmd_ready, 64'd1);
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      cmd_wdata = {$urandom, $urandom};
      cmd_addr  = {$urandom, $urandom};
      cmd_mask  = 8'($urandom);
      if (v.expIssue) begin
         for (int i = 0; i <= v.aDelay; i++) begin
            checkOutput("a_valid", a_valid, 64'd1);
            checkOutput("a_opcode", a_opcode, v.expOpcode);
            checkOutput("a_address", a_address, v.addr);
            checkOutput("a_size", a_size, v.size);
            checkOutput("a_mask", a_mask, v.mask);
            checkOutput("a_data", a_data, v.write ? v.wdata : 64'd0);
            checkOutput("a_source", a_source, src);
            checkOutput("a_param", a_param, 64'd0);
            checkOutput("d_ready_in_a", d_ready, 64'd0);
            if (i == v.aDelay) begin
               a_ready = 1'b1;
               if (v.earlyD) driveD(v, src, rspData);
               else d_valid = 1'b0;
            end else if (v.noiseD) begin
               d_valid = 1'b1; d_error = 1'b1; d_source = ~src; d_opcode = 3'd7; d_data = '1;
            end
            @(posedge clk); @(negedge clk);
            a_ready = 1'b0;
            if (!(i == v.aDelay && v.earlyD)) d_valid = 1'b0;
         end
         if (v.write) memWrite(v.addr, v.mask, v.wdata);
         checkOutput("a_valid_after", a_valid, 64'd0);
         for (int i = 0; i < v.dDelay; i++) begin
            checkOutput("d_ready_wait", d_ready, 64'd1);
            @(posedge clk); @(negedge clk);
         end
         checkOutput("d_ready", d_ready, 64'd1);
         driveD(v, src, rspData);
         @(posedge clk); @(negedge clk);
         d_valid = 1'b0;
      end
      for (int i = 0; i <= v.rspDelay; i++) begin
         checkOutput("rsp_valid", rsp_valid, 64'd1);
         checkOutput("rsp_error", rsp_error, v.expErr);
         checkOutput("rsp_rdata", rsp_rdata, v.expRdata);
         checkOutput("a_valid_in_rsp", a_valid, 64'd0);
         checkOutput("cmd_ready_in_rsp", cmd_ready, 64'd0);
         if (i == v.rspDelay) rsp_ready = 1'b1;
         @(posedge clk); @(negedge clk);
      end
      rsp_ready = 1'b0;
      checkOutput("rsp_valid_after", rsp_valid, 64'd0);
      checkOutput("cmd_ready_after", cmd_ready, 64'd1);
      srcModel = srcModel + 3'd1;
   endtask

   initial begin
      vec_t tbl [14];
      vec_t v;
      bit   wr;
      logic [7:0] sz;
      int   off;

      rst = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_mask = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; a_ready = 1'b0;
      d_valid = 1'b0; d_opcode = '0; d_param = '0; d_size = '0; d_sink = '0; d_source = '0;
      d_data = '0; d_error = 1'b0;

      tbl[0]  = mkVec(1, 64'h10, 3, 8'hFF, 64'hDEADBEEFCAFEBABE, 0, 0, 0, 5'd0,     1, 3'd0, 0, 64'd0);
      tbl[1]  = mkVec(0, 64'h10, 3, 8'hFF, 64'd0,                0, 0, 0, 5'd0,     1, 3'd4, 0, 64'hDEADBEEFCAFEBABE);
      tbl[2]  = mkVec(1, 64'h10, 3, 8'h0F, 64'h1111111122222222, 1, 1, 1, 5'd0,     1, 3'd1, 0, 64'd0);
      tbl[3]  = mkVec(0, 64'h14, 3, 8'hFF, 64'd0,                0, 0, 0, 5'd0,     0, 3'd4, 1, 64'd0);
      tbl[4]  = mkVec(0, 64'h10, 3, 8'hFF, 64'd0,                5, 0, 4, F_NOISE,  1, 3'd4, 0, 64'hDEADBEEF22222222);
      tbl[5]  = mkVec(0, 64'h10, 3, 8'hFF, 64'd0,                0, 2, 0, F_SRCBAD, 1, 3'd4, 1, 64'hDEADBEEF22222222);
      tbl[6]  = mkVec(1, 64'h1C, 2, 8'hF0, 64'hAAAAAAAA00000000, 0, 0, 0, F_DERR,   1, 3'd0, 1, 64'd0);
      tbl[7]  = mkVec(0, 64'h18, 3, 8'hFF, 64'd0,                0, 0, 0, F_EARLY,  1, 3'd4, 0, 64'hAAAAAAAA00000000);
      tbl[8]  = mkVec(0, 64'h1C, 2, 8'hF0, 64'd0,                0, 0, 0, F_OPBAD,  1, 3'd4, 1, 64'hAAAAAAAA00000000);
      tbl[9]  = mkVec(1, 64'h21, 0, 8'h02, 64'h000000000000AB00, 0, 0, 0, 5'd0,     1, 3'd0, 0, 64'd0);
      tbl[10] = mkVec(1, 64'h22, 1, 8'h04, 64'h0000000000CD0000, 0, 0, 0, 5'd0,     1, 3'd1, 0, 64'd0);
      tbl[11] = mkVec(0, 64'h20, 3, 8'hFF, 64'd0,                0, 0, 0, 5'd0,     1, 3'd4, 0, 64'h0000000000CDAB00);
      tbl[12] = mkVec(1, 64'h08, 4, 8'hFF, 64'd1,                0, 0, 0, 5'd0,     0, 3'd0, 1, 64'd0);
      tbl[13] = mkVec(0, 64'h02, 2, 8'hFF, 64'd0,                0, 0, 0, 5'd0,     0, 3'd4, 1, 64'd0);

      // Reset state: every output low, including cmd_ready, until reset is released.
      repeat (2) @(negedge clk);
      checkOutput("reset_cmd_ready", cmd_ready, 64'd0);
      checkOutput("reset_a_valid", a_valid, 64'd0);
      checkOutput("reset_d_ready", d_ready, 64'd0);
      checkOutput("reset_rsp_valid", rsp_valid, 64'd0);
      checkOutput("reset_rsp_error", rsp_error, 64'd0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 64'd0);
      checkOutput("reset_a_source", a_source, 64'd0);
      checkOutput("reset_a_opcode", a_opcode, 64'd0);
      rst = 1'b1;
      #1;
      checkOutput("release_cmd_ready", cmd_ready, 64'd1);
      @(negedge clk);

      $display("[TB] directed vector table");
      for (int i = 0; i < 14; i++) applyStimulus(tbl[i]);

      $display("[TB] reset in D_WAIT");
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 64'h30; cmd_size = 8'd3; cmd_mask = 8'hFF;
      @(posedge clk); @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("abort_a_valid", a_valid, 64'd1);
      a_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      a_ready = 1'b0;
      checkOutput("abort_d_ready_before", d_ready, 64'd1);
      rst = 1'b0;
      #1;
      checkOutput("abort_a_valid_0", a_valid, 64'd0);
      checkOutput("abort_d_ready_0", d_ready, 64'd0);
      checkOutput("abort_rsp_valid_0", rsp_valid, 64'd0);
      checkOutput("abort_cmd_ready_0", cmd_ready, 64'd0);
      checkOutput("abort_a_address_0", a_address, 64'd0);
      srcModel = 3'd0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abort_release_cmd_ready", cmd_ready, 64'd1);
      checkOutput("abort_no_rsp", rsp_valid, 64'd0);

      $display("[TB] rsp_ready high while idle");
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("idle_rsp_valid", rsp_valid, 64'd0);
         checkOutput("idle_cmd_ready", cmd_ready, 64'd1);
      end
      rsp_ready = 1'b0;
      applyStimulus(modelVec(0, 64'h10, 3, 8'hFF, 64'd0));

      $display("[TB] randomized commands");
      for (int n = 0; n < 40; n++) begin
         wr  = 1'($urandom_range(0, 1));
         sz  = 8'($urandom_range(0, 4));
         off = int'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0 && sz <= 8'd3) off = off & ~((1 << int'(sz)) - 1);
         v = modelVec(wr, 64'($urandom_range(0, 7)) * 64'd8 + 64'(off), sz,
                      ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF, {$urandom, $urandom});
         v.aDelay   = int'($urandom_range(0, 3));
         v.dDelay   = int'($urandom_range(0, 3));
         v.rspDelay = int'($urandom_range(0, 3));
         v.dErr     = ($urandom_range(0, 7) == 0);
         v.srcBad   = ($urandom_range(0, 7) == 0);
         v.opBad    = ($urandom_range(0, 7) == 0);
         v.earlyD   = ($urandom_range(0, 3) == 0);
         v.noiseD   = ($urandom_range(0, 3) == 0);
         if (v.earlyD) v.dDelay = 0;
         if (v.expIssue) v.expErr = v.dErr | v.srcBad | v.opBad;
         applyStimulus(v);
      end

`ifdef TL_MASTER_TIMEOUT_EN
      begin
         int waitCycles;
         $display("[TB] D-channel timeout");
         cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 64'h10; cmd_size = 8'd3; cmd_mask = 8'hFF;
         @(posedge clk); @(negedge clk);
         cmd_valid = 1'b0;
         a_ready = 1'b1;
         @(posedge clk); @(negedge clk);
         a_ready = 1'b0;
         waitCycles = 0;
         while (d_ready && waitCycles < 40) begin
            waitCycles++;
            @(posedge clk); @(negedge clk);
         end
         checkOutput("timeout_cycles", waitCycles, 64'd16);
         checkOutput("timeout_rsp_valid", rsp_valid, 64'd1);
         checkOutput("timeout_rsp_error", rsp_error, 64'd1);
         checkOutput("timeout_rsp_rdata", rsp_rdata, 64'd0);
         d_valid = 1'b1; d_source = srcModel; d_opcode = 3'd1; d_error = 1'b0;
         checkOutput("timeout_late_d_ready", d_ready, 64'd0);
         rsp_ready = 1'b1;
         @(posedge clk); @(negedge clk);
         rsp_ready = 1'b0; d_valid = 1'b0;
         checkOutput("timeout_rsp_done", rsp_valid, 64'd0);
         checkOutput("timeout_cmd_ready", cmd_ready, 64'd1);
         srcModel = srcModel + 3'd1;
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
